// File: rtl/lc3_regfile_arbiter_pkg.sv
// Shared constants and FSM state encoding for the LC-3 register-file arbiter.
package lc3_regarb_pkg;

  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DBG_WR = 2'd1,
    DBG_RD = 2'd2,
    CLEAR  = 2'd3
  } regarb_state_e;

endpackage

// File: rtl/lc3_regfile_arbiter_if.sv
// Bundle of CPU writeback, debug handshake and register-file signals around the arbiter.
interface lc3_regfile_arbiter_if;

  logic                                  Cpu_Load;
  logic [lc3_regarb_pkg::REG_ADDR_W-1:0] Cpu_DR;
  logic [lc3_regarb_pkg::WORD_W-1:0]     Cpu_Data;
  logic                                  Cpu_Stall;

  logic                                  Dbg_Req;
  logic                                  Dbg_We;
  logic [lc3_regarb_pkg::REG_ADDR_W-1:0] Dbg_Addr;
  logic [lc3_regarb_pkg::WORD_W-1:0]     Dbg_Wdata;
  logic                                  Dbg_Ack;
  logic [lc3_regarb_pkg::WORD_W-1:0]     Dbg_Rdata;

  logic                                  Clear_Req;
  logic                                  Clear_Done;

  logic [lc3_regarb_pkg::REG_ADDR_W-1:0] RF_DR;
  logic                                  RF_Load;
  logic [lc3_regarb_pkg::WORD_W-1:0]     RF_Bus;
  logic [lc3_regarb_pkg::REG_ADDR_W-1:0] RF_View_Sel;
  logic [lc3_regarb_pkg::WORD_W-1:0]     RF_View;

  // Environment side: CPU, debug panel and the register file itself.
  modport master (
    output Cpu_Load, Cpu_DR, Cpu_Data, Dbg_Req, Dbg_We, Dbg_Addr, Dbg_Wdata,
           Clear_Req, RF_View,
    input  Cpu_Stall, Dbg_Ack, Dbg_Rdata, Clear_Done, RF_DR, RF_Load, RF_Bus,
           RF_View_Sel
  );

  modport slave (
    input  Cpu_Load, Cpu_DR, Cpu_Data, Dbg_Req, Dbg_We, Dbg_Addr, Dbg_Wdata,
           Clear_Req, RF_View,
    output Cpu_Stall, Dbg_Ack, Dbg_Rdata, Clear_Done, RF_DR, RF_Load, RF_Bus,
           RF_View_Sel
  );

endinterface

// File: rtl/lc3_regfile_arbiter_starve_ctr.sv
// Saturating lost-arbitration counter; hit flags that the debug requester must now win.
module regarb_starve_ctr #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;

  // Hold beats clear so a request parked behind a zero-fill keeps its accumulated wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!hold) begin
      if (clr) begin
        cnt_q <= '0;
      end else if (inc && (cnt_q != LIMIT_C)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/lc3_regfile_arbiter.sv
// Shares the LC-3 register-file write/view ports between CPU writeback and a debug requester.
// Optional zero-fill of R0..R7 is built only when REGARB_CLEAR_EN is defined.
module lc3_regfile_arbiter
  import lc3_regarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 8
) (
  input logic                 Clk,
  input logic                 Reset,
  lc3_regfile_arbiter_if.slave bus
);

  regarb_state_e         state_q, next_state;
  logic                  grant;
  logic                  starve_hit;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0]     data_q;
  logic                  ack_q;
  logic [WORD_W-1:0]     rdata_q;

`ifdef REGARB_CLEAR_EN
  logic [REG_ADDR_W-1:0] clr_idx_q;
  logic                  done_q;
`else
  logic                  unused_clear_req;
  assign unused_clear_req = bus.Clear_Req;
`endif

  regarb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk  (Clk),
    .rst  (Reset),
    .inc  ((state_q == IDLE) && bus.Dbg_Req && !grant),
    .clr  (!bus.Dbg_Req || grant),
    .hold (state_q == CLEAR),
    .hit  (starve_hit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // In IDLE the CPU owns the write port outright; debug only wins on a free or starved cycle.
  always_comb begin
    next_state      = state_q;
    grant           = 1'b0;
    bus.RF_DR       = bus.Cpu_DR;
    bus.RF_Load     = bus.Cpu_Load;
    bus.RF_Bus      = bus.Cpu_Data;
    bus.RF_View_Sel = bus.Dbg_Addr;
    case (state_q)
      IDLE: begin
`ifdef REGARB_CLEAR_EN
        if (bus.Clear_Req) next_state = CLEAR;
        else
`endif
        if (bus.Dbg_Req && (!bus.Cpu_Load || starve_hit)) begin
          grant      = 1'b1;
          next_state = bus.Dbg_We ? DBG_WR : DBG_RD;
        end
      end
      DBG_WR: begin
        bus.RF_Load = 1'b1;
        bus.RF_DR   = addr_q;
        bus.RF_Bus  = data_q;
        next_state  = IDLE;
      end
      DBG_RD: begin
        bus.RF_Load     = 1'b0;
        bus.RF_View_Sel = addr_q;
        next_state      = IDLE;
      end
`ifdef REGARB_CLEAR_EN
      CLEAR: begin
        bus.RF_Load = 1'b1;
        bus.RF_DR   = clr_idx_q;
        bus.RF_Bus  = '0;
        if (clr_idx_q == REG_ADDR_W'(NUM_REGS - 1)) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Debug transaction bookkeeping: latch on grant, capture the view, pulse ack afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= (state_q == DBG_WR) || (state_q == DBG_RD);
      if (grant) begin
        addr_q <= bus.Dbg_Addr;
        data_q <= bus.Dbg_Wdata;
      end
      if (state_q == DBG_RD) rdata_q <= bus.RF_View;
    end
  end

`ifdef REGARB_CLEAR_EN
  // clr_idx wraps back to 0 on its own after R7, so no explicit reload is needed on exit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clr_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == CLEAR) && (clr_idx_q == REG_ADDR_W'(NUM_REGS - 1));
      if (state_q == IDLE && bus.Clear_Req) clr_idx_q <= '0;
      else if (state_q == CLEAR)            clr_idx_q <= clr_idx_q + 1'b1;
    end
  end

  assign bus.Clear_Done = done_q;
`else
  assign bus.Clear_Done = 1'b0;
`endif

  assign bus.Cpu_Stall = (state_q != IDLE);
  assign bus.Dbg_Ack   = ack_q;
  assign bus.Dbg_Rdata = rdata_q;

endmodule
